// File: rtl/tone_det_pkg.sv
// Shared definitions for the Goertzel tone detector.
//   tone_state_e : sequencing states of the per-sample and end-of-frame datapath
//   COEFF_FRAC   : fractional bits of the Goertzel coefficient (Q2.14)
//   COEFF_W      : coefficient width
//   SAMPLE_W     : input sample width
//   COEFF_750HZ  : 2*cos(2*pi*4/64), bin k=4 of a 64-sample frame at 12 kHz
//   COEFF_440HZ  : 2*cos(2*pi*440/12000), non-integer bin tuned to 440 Hz
package tone_det_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StAdd,
        StP1,
        StP2,
        StP3,
        StOut
    } tone_state_e;

    localparam int unsigned COEFF_FRAC  = 14;
    localparam int unsigned COEFF_W     = 16;
    localparam int unsigned SAMPLE_W    = 8;
    localparam int          COEFF_750HZ = 30274;
    localparam int          COEFF_440HZ = 31902;

endpackage

// File: rtl/sat_resize.sv
// Signed width reduction IN_W -> OUT_W (IN_W > OUT_W).
// Build option TONE_DET_SAT_EN: defined -> clamp to the OUT_W signed range,
// undefined -> drop the upper bits (two's-complement wrap).
//   din_i  : signed input, IN_W bits
//   dout_o : signed output, OUT_W bits
module sat_resize #(
    parameter int unsigned IN_W  = 26,
    parameter int unsigned OUT_W = 24
) (
    input  logic signed [IN_W-1:0]  din_i,
    output logic signed [OUT_W-1:0] dout_o
);

`ifdef TONE_DET_SAT_EN
    localparam logic signed [IN_W-1:0] MaxVal = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] MinVal = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    always_comb begin
        dout_o = din_i[OUT_W-1:0];
        if (din_i > MaxVal) begin
            dout_o = MaxVal[OUT_W-1:0];
        end else if (din_i < MinVal) begin
            dout_o = MinVal[OUT_W-1:0];
        end
    end
`else
    logic unused_hi;

    assign unused_hi = ^din_i[IN_W-1:OUT_W];
    assign dout_o    = din_i[OUT_W-1:0];
`endif

endmodule

// File: rtl/goertzel_tone_detector.sv
// Goertzel single-bin tone detector over frames of N_SAMPLES 8-bit signed samples.
// Each accepted sample takes MUL and ADD cycles; after the last sample of a frame
// P1..P3 form the power terms and OUT publishes power/detect and restarts the frame.
// Build option TONE_DET_SAT_EN: saturate (instead of wrap) the state update.
//   clk_in          : clock
//   rst_in          : synchronous active-high reset
//   step_in         : sample strobe (accepted only in IDLE)
//   sample_in       : signed sample
//   power_out       : last frame bin power, clamped to [0, 2^POWER_W-1]
//   power_valid_out : one-cycle pulse when power_out/detect_out update
//   detect_out      : power_out > THRESH
//   overrun_out     : sticky, a strobe arrived while busy
module goertzel_tone_detector
    import tone_det_pkg::*;
#(
    parameter int unsigned      N_SAMPLES = 64,
    parameter int               COEFF     = 30274,
    parameter int unsigned      STATE_W   = 24,
    parameter int unsigned      POWER_W   = 48,
    parameter longint unsigned  THRESH    = 16384
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                step_in,
    input  logic [SAMPLE_W-1:0] sample_in,
    output logic [POWER_W-1:0]  power_out,
    output logic                power_valid_out,
    output logic                detect_out,
    output logic                overrun_out
);

    localparam int unsigned CNT_W  = $clog2(N_SAMPLES);
    localparam int unsigned SMSB   = STATE_W - 1;
    localparam int unsigned WIDE_W = STATE_W + 2;
    localparam int unsigned PROD_W = COEFF_W + STATE_W;
    localparam int unsigned SQ_W   = 2 * STATE_W;
    localparam int unsigned C_W    = 2 * STATE_W + 2;
    localparam int unsigned P_W    = 2 * STATE_W + 3;
    localparam int unsigned EXT_W  = ((P_W > POWER_W) ? P_W : POWER_W) + 1;

    localparam logic signed [COEFF_W-1:0] CoeffS = COEFF_W'(COEFF);
    localparam logic signed [EXT_W-1:0]   PMax   = {{(EXT_W-POWER_W){1'b0}}, {POWER_W{1'b1}}};

    tone_state_e               state_q, state_d;
    logic [SAMPLE_W-1:0]       x_q, x_d;
    logic signed [WIDE_W-1:0]  m_q, m_d;
    logic signed [STATE_W-1:0] s1_q, s1_d, s2_q, s2_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic signed [SQ_W-1:0]    a_q, a_d, b_q, b_d;
    logic signed [C_W-1:0]     c_q, c_d;
    logic [POWER_W-1:0]        power_q, power_d;
    logic                      valid_q, valid_d;
    logic                      detect_q, detect_d;
    logic                      overrun_q, overrun_d;

    // coeff * s1 in Q2.14, reused by MUL and P3
    logic signed [PROD_W-1:0]  coeff_ext, s1_pext, prod, m_full;
    logic signed [WIDE_W-1:0]  m_trunc;
    logic                      unused_m;

    assign coeff_ext = {{STATE_W{CoeffS[COEFF_W-1]}}, CoeffS};
    assign s1_pext   = {{COEFF_W{s1_q[SMSB]}}, s1_q};
    assign prod      = coeff_ext * s1_pext;
    assign m_full    = prod >>> COEFF_FRAC;
    // |coeff| < 2, so the shifted product always fits in STATE_W+2 bits
    assign m_trunc   = m_full[WIDE_W-1:0];
    assign unused_m  = ^m_full[PROD_W-1:WIDE_W];

    // s0 = x + m - s2 at STATE_W+2 bits, then resized back to STATE_W
    logic signed [WIDE_W-1:0]  x_ext, s2_wext, s0_wide;
    logic signed [STATE_W-1:0] s0;

    assign x_ext   = {{(WIDE_W-SAMPLE_W){x_q[SAMPLE_W-1]}}, x_q};
    assign s2_wext = {{2{s2_q[SMSB]}}, s2_q};
    assign s0_wide = x_ext + m_q - s2_wext;

    sat_resize #(
        .IN_W  (WIDE_W),
        .OUT_W (STATE_W)
    ) u_sat_resize (
        .din_i  (s0_wide),
        .dout_o (s0)
    );

    // power terms, operands sign-extended to the full product width
    logic signed [SQ_W-1:0]  s1_sq, s2_sq;
    logic signed [C_W-1:0]   m_cext, s2_cext;
    logic signed [EXT_W-1:0] p_ext;

    assign s1_sq   = {{STATE_W{s1_q[SMSB]}}, s1_q};
    assign s2_sq   = {{STATE_W{s2_q[SMSB]}}, s2_q};
    assign m_cext  = {{(C_W-WIDE_W){m_trunc[WIDE_W-1]}}, m_trunc};
    assign s2_cext = {{(C_W-STATE_W){s2_q[SMSB]}}, s2_q};
    assign p_ext   = {{(EXT_W-SQ_W){a_q[SQ_W-1]}}, a_q}
                   + {{(EXT_W-SQ_W){b_q[SQ_W-1]}}, b_q}
                   - {{(EXT_W-C_W){c_q[C_W-1]}}, c_q};

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        m_d       = m_q;
        s1_d      = s1_q;
        s2_d      = s2_q;
        count_d   = count_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        power_d   = power_q;
        detect_d  = detect_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q;

        if (step_in && (state_q != StIdle)) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (step_in) begin
                    x_d     = sample_in;
                    state_d = StMul;
                end
            end
            StMul: begin
                m_d     = m_trunc;
                state_d = StAdd;
            end
            StAdd: begin
                s2_d    = s1_q;
                s1_d    = s0;
                count_d = count_q + CNT_W'(1);
                state_d = (count_q == CNT_W'(N_SAMPLES - 1)) ? StP1 : StIdle;
            end
            StP1: begin
                a_d     = s1_sq * s1_sq;
                state_d = StP2;
            end
            StP2: begin
                b_d     = s2_sq * s2_sq;
                state_d = StP3;
            end
            StP3: begin
                c_d     = m_cext * s2_cext;
                state_d = StOut;
            end
            StOut: begin
                if (p_ext[EXT_W-1]) begin
                    power_d = '0;
                end else if (p_ext > PMax) begin
                    power_d = '1;
                end else begin
                    power_d = p_ext[POWER_W-1:0];
                end
                detect_d = (power_d > POWER_W'(THRESH));
                valid_d  = 1'b1;
                s1_d     = '0;
                s2_d     = '0;
                count_d  = '0;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= StIdle;
            x_q       <= '0;
            m_q       <= '0;
            s1_q      <= '0;
            s2_q      <= '0;
            count_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            power_q   <= '0;
            detect_q  <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            m_q       <= m_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            count_q   <= count_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            power_q   <= power_d;
            detect_q  <= detect_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign power_out       = power_q;
    assign power_valid_out = valid_q;
    assign detect_out      = detect_q;
    assign overrun_out     = overrun_q;

endmodule

// File: tb/tb_goertzel_tone_detector.sv
// Self-checking bench: two detectors (STATE_W 24 and 12) share the stimulus; each frame's
// power is predicted by an arithmetic Goertzel model over the frame's sample list.
module tb_goertzel_tone_detector;

    localparam int     N      = 64;
    localparam int     COEFF  = 30274;
    localparam longint THRESH = 16384;
`ifdef TONE_DET_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        step = 1'b0;
    logic [7:0]  sample = 8'h00;
    logic [47:0] power1, power2;
    logic        v1, d1, o1, v2, d2, o2;

    goertzel_tone_detector #(.STATE_W(24)) dut1 (
        .clk_in(clk), .rst_in(rst), .step_in(step), .sample_in(sample),
        .power_out(power1), .power_valid_out(v1), .detect_out(d1), .overrun_out(o1)
    );

    goertzel_tone_detector #(.STATE_W(12)) dut2 (
        .clk_in(clk), .rst_in(rst), .step_in(step), .sample_in(sample),
        .power_out(power2), .power_valid_out(v2), .detect_out(d2), .overrun_out(o2)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int pulse1   = 0;
    int base1    = 0;
    int frame_x[N];

    always @(posedge clk) begin
        if (v1 === 1'b1) pulse1 <= pulse1 + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reduce v to a w-bit signed state: clamp or modular wrap
    function automatic longint resize(longint v, int w);
        longint lim = longint'(1) << (w - 1);
        longint r;
        if (SAT) begin
            if (v > lim - 1) return lim - 1;
            if (v < -lim) return -lim;
            return v;
        end
        r = v % (2 * lim);
        if (r < 0) r += 2 * lim;
        if (r >= lim) r -= 2 * lim;
        return r;
    endfunction

    function automatic longint model_power(int w);
        longint s1 = 0, s2 = 0, s0, p;
        longint cap = (longint'(1) << 48) - 1;
        for (int n = 0; n < N; n++) begin
            s0 = resize(longint'(frame_x[n]) + ((COEFF * s1) >>> 14) - s2, w);
            s2 = s1;
            s1 = s0;
        end
        p = s1 * s1 + s2 * s2 - ((COEFF * s1) >>> 14) * s2;
        if (p < 0) p = 0;
        if (p > cap) p = cap;
        return p;
    endfunction

    function automatic int round_r(real v);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction

    task automatic fill_sine(input real f, input real amp);
        for (int n = 0; n < N; n++)
            frame_x[n] = round_r(amp * $sin(2.0 * 3.14159265358979 * f * n / 12000.0));
    endtask

    task automatic fill_const_or_square(input int kind);
        for (int n = 0; n < N; n++) begin
            if (kind == 0) frame_x[n] = 0;
            else if (kind == 1) frame_x[n] = ((n % 16) < 8) ? 127 : -127;
            else frame_x[n] = int'($urandom_range(255, 0)) - 128;
        end
    endtask

    task automatic accept(input int x);
        logic [31:0] xv;
        xv     = x;
        step   = 1'b1;
        sample = xv[7:0];
        @(negedge clk);
        step   = 1'b0;
    endtask

    // Send frame_x[0..cnt-1]; gap (in cycles between strobes) random in [smin,smax], >= 3
    task automatic send_samples(input int cnt, input int smin, input int smax);
        for (int i = 0; i < cnt; i++) begin
            accept(frame_x[i]);
            if (i != cnt - 1) repeat (int'($urandom_range(smax, smin)) - 1) @(negedge clk);
        end
    endtask

    // Wait for the power pulse, then check latency, both results and the single-pulse rule
    task automatic finish_frame(input string tag, input int exp_k);
        int     k = -1;
        longint e1, e2;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (v1 === 1'b1) begin
                k = i;
                break;
            end
        end
        e1 = model_power(24);
        e2 = model_power(12);
        chk({tag, "_latency"}, k, exp_k);
        chk({tag, "_power"}, power1, e1);
        chk({tag, "_detect"}, d1, e1 > THRESH);
        chk({tag, "_valid12"}, v2, 1'b1);
        chk({tag, "_power12"}, power2, e2);
        chk({tag, "_detect12"}, d2, e2 > THRESH);
        @(negedge clk);
        chk({tag, "_pulse_width"}, v1, 1'b0);
        chk({tag, "_pulse_count"}, pulse1 - base1, 1);
    endtask

    task automatic run_frame(input string tag, input int smin, input int smax);
        base1 = pulse1;
        send_samples(N, smin, smax);
        finish_frame(tag, 6);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_power", power1, 0);
        chk("reset_valid", v1, 0);
        chk("reset_detect", d1, 0);
        chk("reset_overrun", o1, 0);
        repeat (2) @(negedge clk);

        fill_sine(750.0, 8.0);
        run_frame("tone750", 16, 16);
        chk("tone750_range", (power1 >= 48'd58982) && (power1 <= 48'd72090), 1'b1);
        chk("tone750_detect_on", d1, 1'b1);

        fill_sine(440.0, 8.0);
        run_frame("tone440", 16, 16);
        chk("tone440_below", power1 < 48'd16384, 1'b1);

        fill_const_or_square(0);
        run_frame("zeros", 16, 16);
        chk("zeros_power0", power1, 0);

        fill_sine(750.0, 8.0);
        run_frame("tone750_again", 3, 16);
        chk("tone750_again_detect", d1, 1'b1);

        fill_const_or_square(1);
        run_frame("square", 3, 6);

        // Strobe during P1 of the frame end is dropped and flags overrun
        chk("overrun_before", o1, 0);
        fill_sine(750.0, 8.0);
        base1 = pulse1;
        send_samples(N, 3, 8);
        repeat (2) @(negedge clk);
        accept(85);
        finish_frame("overrun_frame", 3);
        chk("overrun_set", o1, 1'b1);
        chk("overrun_set12", o2, 1'b1);
        fill_const_or_square(2);
        base1 = pulse1;
        send_samples(N - 1, 3, 8);
        repeat (3) @(negedge clk);
        chk("after_overrun_no_early", pulse1 - base1, 0);
        accept(frame_x[N - 1]);
        finish_frame("after_overrun", 6);
        chk("overrun_sticky", o1, 1'b1);

        // Reset mid-frame discards the partial frame
        fill_const_or_square(2);
        base1 = pulse1;
        send_samples(30, 3, 8);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("midreset_power", power1, 0);
        chk("midreset_detect", d1, 0);
        chk("midreset_overrun", o1, 0);
        fill_sine(750.0, 8.0);
        send_samples(N, 3, 12);
        finish_frame("post_reset", 6);

        for (int f = 0; f < 3; f++) begin
            fill_const_or_square(2);
            run_frame($sformatf("random%0d", f), 3, 7);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
